// File: rtl/merge_pkg.sv
// Shared constants for the merge sorter: pipeline depth and the Batcher
// odd-even merge compare-exchange tables for two ascending lists of n keys.
package merge_pkg;

    function automatic int unsigned stages_f(input int unsigned n);
        return 32'($clog2(2 * n));
    endfunction

    // Index distance between the two members of every pair in a layer.
    function automatic int unsigned cx_dist(input int unsigned n, input int unsigned layer);
        return n >> layer;
    endfunction

    function automatic int unsigned cx_pairs(input int unsigned n, input int unsigned layer);
        return (layer == 0) ? n : n - cx_dist(n, layer);
    endfunction

    // Lower index of pair p; the first layer pairs i with i+n, later layers
    // form groups of k pairs starting at k, 3k, 5k ...
    function automatic int unsigned cx_lo(input int unsigned n, input int unsigned layer,
                                          input int unsigned p);
        int unsigned k;
        k = cx_dist(n, layer);
        if (layer == 0) begin
            return p;
        end
        return k + 2 * k * (p / k) + (p % k);
    endfunction

    function automatic bit cx_used(input int unsigned n, input int unsigned layer,
                                   input int unsigned idx);
        bit used;
        used = 1'b0;
        for (int unsigned p = 0; p < cx_pairs(n, layer); p++) begin
            if (cx_lo(n, layer, p) == idx || cx_lo(n, layer, p) + cx_dist(n, layer) == idx) begin
                used = 1'b1;
            end
        end
        return used;
    endfunction

endpackage

// File: rtl/cmp_exchange.sv
// Combinational compare-exchange: min to the lower index, max to the higher;
// equal keys pass straight through.
module cmp_exchange #(
    parameter int unsigned WIDTH = 3
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] lo_o,
    output logic [WIDTH-1:0] hi_o
);
    always_comb begin
        lo_o = a_i;
        hi_o = b_i;
        if (b_i < a_i) begin
            lo_o = b_i;
            hi_o = a_i;
        end
    end
endmodule

// File: rtl/merge_pipe_sorter.sv
// Pipelined Batcher odd-even merger of two ascending key lists, one comparator
// layer per registered stage, with load staging and a global-stall handshake.
module merge_pipe_sorter
    import merge_pkg::*;
#(
    parameter int unsigned WIDTH  = 3,
    parameter int unsigned N      = 4,
    parameter int unsigned STAGES = stages_f(N)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             load,
    input  logic [2*N*WIDTH-1:0]   inba,
    input  logic                   descend,
    output logic                   in_ready,
    output logic [2*N*WIDTH-1:0]   c,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   ovf
);
    localparam int unsigned M  = 2 * N;
    localparam int unsigned LW = N * WIDTH;
    localparam int unsigned DW = M * WIDTH;

    logic [LW-1:0]     a_q, a_d, b_q, b_d;
    logic [1:0]        full_q, full_d;
    logic              ovf_q, ovf_d;
    logic [1:0]        accept;
    logic              adv, issue;

    logic [STAGES-1:0] valid_q;
    logic [STAGES-2:0] desc_q;
    logic [DW-1:0]     stg_q   [STAGES];
    logic [DW-1:0]     stg_d   [STAGES];
    logic [DW-1:0]     lay_out [STAGES];
    logic [DW-1:0]     rev;

    assign out_valid = valid_q[STAGES-1];
    assign c         = stg_q[STAGES-1];
    assign ovf       = ovf_q;
    assign in_ready  = !(&full_q) | issue;

    // Staging: a half accepts a load when empty or being drained by this issue.
    always_comb begin
        adv    = !out_valid | out_ready;
        issue  = full_q[0] & full_q[1] & adv;
        accept = load & ~(full_q & ~{2{issue}});
        full_d = (full_q & ~{2{issue}}) | accept;
        ovf_d  = ovf_q | (|(load & ~accept));
        a_d    = accept[0] ? inba[LW-1:0]  : a_q;
        b_d    = accept[1] ? inba[DW-1:LW] : b_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q    <= '0;
            b_q    <= '0;
            full_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            full_q <= full_d;
            ovf_q  <= ovf_d;
        end
    end

    for (genvar l = 0; l < STAGES; l++) begin : g_layer
        logic [DW-1:0] lay_i;
        logic [DW-1:0] lay_o;

        if (l == 0) begin : g_src_stage
            assign lay_i = {b_q, a_q};
        end else begin : g_src_reg
            assign lay_i = stg_q[l-1];
        end

        for (genvar p = 0; p < N; p++) begin : g_pair
            if (p < cx_pairs(N, l)) begin : g_cx
                localparam int unsigned LO = cx_lo(N, l, p);
                localparam int unsigned HI = LO + cx_dist(N, l);
                cmp_exchange #(.WIDTH(WIDTH)) u_cx (
                    .a_i  (lay_i[LO*WIDTH +: WIDTH]),
                    .b_i  (lay_i[HI*WIDTH +: WIDTH]),
                    .lo_o (lay_o[LO*WIDTH +: WIDTH]),
                    .hi_o (lay_o[HI*WIDTH +: WIDTH])
                );
            end
        end

        for (genvar e = 0; e < M; e++) begin : g_pass
            if (!cx_used(N, l, e)) begin : g_wire
                assign lay_o[e*WIDTH +: WIDTH] = lay_i[e*WIDTH +: WIDTH];
            end
        end

        assign lay_out[l] = lay_o;
    end

    // Descending order is an element-wise reversal folded into the last register.
    always_comb begin
        rev = '0;
        for (int unsigned e = 0; e < M; e++) begin
            rev[e*WIDTH +: WIDTH] = lay_out[STAGES-1][(M-1-e)*WIDTH +: WIDTH];
        end
        for (int unsigned l = 0; l < STAGES; l++) begin
            stg_d[l] = lay_out[l];
        end
        if (desc_q[STAGES-2]) begin
            stg_d[STAGES-1] = rev;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            desc_q  <= '0;
            for (int unsigned l = 0; l < STAGES; l++) begin
                stg_q[l] <= '0;
            end
        end else if (adv) begin
            valid_q <= STAGES'({valid_q, issue});
            desc_q  <= (STAGES-1)'({desc_q, descend});
            for (int unsigned l = 0; l < STAGES; l++) begin
                stg_q[l] <= stg_d[l];
            end
        end
    end

endmodule

// File: tb/tb_merge_pipe_sorter.sv
// Directed bench for merge_pipe_sorter with WIDTH=3, N=4 (three-stage pipe).
module tb_merge_pipe_sorter;
    logic        clk;
    logic        rst;
    logic [1:0]  load;
    logic [23:0] inba;
    logic        descend;
    logic        in_ready;
    logic [23:0] c;
    logic        out_valid;
    logic        out_ready;
    logic        ovf;

    int n_cmp = 0;
    int n_bad = 0;

    // Element 0 sits in the low bits of each 12-bit list.
    localparam logic [11:0] A1   = {3'd7, 3'd5, 3'd3, 3'd1};
    localparam logic [11:0] B1   = {3'd6, 3'd4, 3'd2, 3'd0};
    localparam logic [23:0] CASC = {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
    localparam logic [23:0] CDSC = {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    localparam logic [11:0] A2   = {3'd2, 3'd2, 3'd2, 3'd2};
    localparam logic [11:0] B2   = {3'd7, 3'd6, 3'd2, 3'd2};
    localparam logic [23:0] C2   = {3'd7, 3'd6, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2};
    localparam logic [23:0] P2   = {12'o7777, 12'o0000};
    localparam logic [23:0] C_P2 = {12'o7777, 12'o0000};
    localparam logic [23:0] P3   = {3'd3, 3'd2, 3'd1, 3'd0, 3'd7, 3'd6, 3'd5, 3'd4};
    localparam logic [23:0] P4   = {3'd6, 3'd2, 3'd2, 3'd0, 3'd3, 3'd3, 3'd1, 3'd1};
    localparam logic [23:0] C_P4 = {3'd6, 3'd3, 3'd3, 3'd2, 3'd2, 3'd1, 3'd1, 3'd0};

    merge_pipe_sorter #(.WIDTH(3), .N(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .inba      (inba),
        .descend   (descend),
        .in_ready  (in_ready),
        .c         (c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ovf       (ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b0; load = 2'b00; inba = '0; descend = 1'b0; out_ready = 1'b1;
        tick;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_ovf",       32'(ovf),       32'd0);
        chk("rst_c",         32'(c),         32'd0);
        tick;
        rst = 1'b1;
        tick;

        // Ascending merge, both halves in one load.
        load = 2'b11; inba = {B1, A1};
        tick;
        load = 2'b00; inba = '0;
        chk("asc_in_ready_issue", 32'(in_ready), 32'd1);
        tick;
        chk("asc_lat1", 32'(out_valid), 32'd0);
        tick;
        chk("asc_lat2", 32'(out_valid), 32'd0);
        tick;
        chk("asc_valid", 32'(out_valid), 32'd1);
        chk("asc_c",     32'(c),         32'(CASC));
        tick;
        chk("asc_drain", 32'(out_valid), 32'd0);

        // Same pair, descending.
        load = 2'b11; inba = {B1, A1}; descend = 1'b1;
        tick;
        load = 2'b00;
        tick;
        descend = 1'b0;
        tick;
        tick;
        chk("dsc_valid", 32'(out_valid), 32'd1);
        chk("dsc_c",     32'(c),         32'(CDSC));

        // Split loads with equal keys; garbage in the low half must not reach A.
        load = 2'b01; inba = {12'o7777, A2};
        tick;
        chk("split_in_ready", 32'(in_ready), 32'd1);
        load = 2'b10; inba = {B2, 12'o7777};
        tick;
        load = 2'b00; inba = '0;
        tick;
        tick;
        chk("split_lat", 32'(out_valid), 32'd0);
        tick;
        chk("split_valid", 32'(out_valid), 32'd1);
        chk("split_c",     32'(c),         32'(C2));
        tick;

        // Back-to-back issue into a stalled consumer.
        out_ready = 1'b0;
        load = 2'b11; inba = {B1, A1};
        tick;
        inba = P2; descend = 1'b0;
        tick;
        inba = P3; descend = 1'b0;
        tick;
        inba = P4; descend = 1'b1;
        tick;
        load = 2'b00; inba = '0; descend = 1'b0;
        chk("stall_valid",    32'(out_valid), 32'd1);
        chk("stall_c0",       32'(c),         32'(CASC));
        chk("stall_in_ready", 32'(in_ready),  32'd0);
        tick;
        tick;
        chk("stall_hold_valid", 32'(out_valid), 32'd1);
        chk("stall_hold_c",     32'(c),         32'(CASC));
        chk("stall_hold_ready", 32'(in_ready),  32'd0);
        chk("stall_no_ovf",     32'(ovf),       32'd0);
        out_ready = 1'b1;
        #1;
        chk("release_in_ready", 32'(in_ready), 32'd1);
        tick;
        chk("rel1_valid", 32'(out_valid), 32'd1);
        chk("rel1_c",     32'(c),         32'(C_P2));
        tick;
        chk("rel2_valid", 32'(out_valid), 32'd1);
        chk("rel2_c",     32'(c),         32'(CDSC));
        tick;
        chk("rel3_valid", 32'(out_valid), 32'd1);
        chk("rel3_c",     32'(c),         32'(C_P4));
        tick;
        chk("rel_drain", 32'(out_valid), 32'd0);

        // Overflow: second A load while B is empty is dropped.
        load = 2'b01; inba = {12'o0, A1};
        tick;
        inba = '0;
        tick;
        chk("ovf_set", 32'(ovf), 32'd1);
        load = 2'b10; inba = {B1, 12'o0};
        tick;
        load = 2'b00; inba = '0;
        tick;
        tick;
        tick;
        chk("ovf_a_kept_valid", 32'(out_valid), 32'd1);
        chk("ovf_a_kept_c",     32'(c),         32'(CASC));
        chk("ovf_sticky",       32'(ovf),       32'd1);
        tick;

        // Reset with two pairs in flight.
        load = 2'b11; inba = {B1, A1};
        tick;
        inba = P2;
        tick;
        load = 2'b00; inba = '0;
        tick;
        tick;
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        rst = 1'b0;
        #1;
        chk("midrst_valid",    32'(out_valid), 32'd0);
        chk("midrst_c",        32'(c),         32'd0);
        chk("midrst_ovf",      32'(ovf),       32'd0);
        chk("midrst_in_ready", 32'(in_ready),  32'd1);
        tick;
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick;
            chk("post_rst_idle", 32'(out_valid), 32'd0);
        end
        load = 2'b11; inba = P4;
        tick;
        load = 2'b00; inba = '0;
        tick;
        tick;
        chk("post_rst_lat", 32'(out_valid), 32'd0);
        tick;
        chk("post_rst_valid", 32'(out_valid), 32'd1);
        chk("post_rst_c",     32'(c),         32'(C_P4));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
